// File: rtl/dmem_bridge.sv
// dmem_bridge: single-cycle memory-stage request to req/gnt/rvalid data bus, with stall and load extension.
// Optional bus watchdog enabled by defining DMEM_TIMEOUT_EN.
module dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        dce,
  input  logic [31:0] daddr,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  input  logic [3:0]  dre,
  input  logic        extendtype,
  input  logic        flush,
  output logic        stallreq,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t      r_state;
  logic        r_killed;
  logic [3:0]  r_dre;
  logic        r_ext;
  logic        w_valid;
  logic        w_timeout;
  logic [31:0] w_ext;
  assign w_valid  = dce & ((|we) | (|dre));
  assign bus_req  = r_state == REQ;
  assign stallreq = (r_state == REQ) | (r_state == RESP) | ((r_state == IDLE) & w_valid & ~flush);
  // dre bit 3 is byte offset 0; unlisted lane codes read as zero
  assign w_ext =
    (r_dre == 4'b1111) ? bus_rdata :
    (r_dre == 4'b1100) ? {{16{r_ext & bus_rdata[15]}}, bus_rdata[15:0]} :
    (r_dre == 4'b0011) ? {{16{r_ext & bus_rdata[31]}}, bus_rdata[31:16]} :
    (r_dre == 4'b1000) ? {{24{r_ext & bus_rdata[7]}}, bus_rdata[7:0]} :
    (r_dre == 4'b0100) ? {{24{r_ext & bus_rdata[15]}}, bus_rdata[15:8]} :
    (r_dre == 4'b0010) ? {{24{r_ext & bus_rdata[23]}}, bus_rdata[23:16]} :
    (r_dre == 4'b0001) ? {{24{r_ext & bus_rdata[31]}}, bus_rdata[31:24]} : 32'd0;
`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] r_cnt;
  logic          w_stay;
  assign w_timeout = ((r_state == REQ) | (r_state == RESP)) & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_stay = ((r_state == REQ) & ~bus_gnt & ~flush | (r_state == RESP) & ~bus_rvalid) & ~w_timeout;
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) r_cnt <= '0;
    else r_cnt <= w_stay ? r_cnt + 1'b1 : '0;
  end
`else
  // watchdog compiled out; the parameter only folds into a constant-false term
  assign w_timeout = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_state    <= IDLE;
      r_killed   <= 1'b0;
      r_dre      <= 4'd0;
      r_ext      <= 1'b0;
      bus_wr     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wstrb  <= 4'd0;
      bus_wdata  <= 32'd0;
      load_data  <= 32'd0;
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      bus_err    <= 1'b0;
      case (r_state)
        IDLE: if (w_valid & ~flush) begin
          r_state   <= REQ;
          bus_addr  <= daddr & ~32'd3;
          bus_wstrb <= we;
          bus_wdata <= din;
          bus_wr    <= |we;
          r_dre     <= dre;
          r_ext     <= extendtype;
        end
        REQ: if (bus_gnt) begin
          r_state  <= RESP;
          r_killed <= flush;
        end else if (flush) begin
          r_state <= IDLE;
        end else if (w_timeout) begin
          r_state   <= DONE;
          bus_err   <= 1'b1;
          load_data <= 32'd0;
        end
        RESP: if (bus_rvalid) begin
          r_killed <= 1'b0;
          if (r_killed | flush) r_state <= IDLE;
          else begin
            r_state    <= DONE;
            load_valid <= ~bus_wr;
            load_data  <= bus_wr ? 32'd0 : w_ext;
          end
        end else if (w_timeout) begin
          r_state   <= DONE;
          r_killed  <= 1'b0;
          bus_err   <= 1'b1;
          load_data <= 32'd0;
        end else if (flush) begin
          r_killed <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: randomized transactions against a lane/extension reference model.
module tb_dmem_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dce = 1'b0;
  logic [31:0] daddr = '0;
  logic [3:0]  we = '0;
  logic [31:0] din = '0;
  logic [3:0]  dre = '0;
  logic        extendtype = 1'b0;
  logic        flush = 1'b0;
  logic        stallreq, load_valid, bus_err, bus_req, bus_wr;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ld = '0;

  dmem_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .cpu_clk_50M(clk), .cpu_rst(rst), .dce(dce), .daddr(daddr), .we(we), .din(din),
    .dre(dre), .extendtype(extendtype), .flush(flush), .stallreq(stallreq),
    .load_data(load_data), .load_valid(load_valid), .bus_err(bus_err),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // lanes named by dre, offset = position from bit 3; only contiguous aligned sizes 1/2/4 are legal
  function automatic logic [31:0] ref_ld(input logic [3:0] r, input logic e, input logic [31:0] rd);
    int n, off;
    logic [31:0] v;
    bit legal;
    n = 0;
    off = 0;
    for (int i = 3; i >= 0; i--) if (r[i]) begin
      if (n == 0) off = 3 - i;
      n++;
    end
    legal = (n == 1) || (n == 4) || (n == 2 && (off == 0 || off == 2) && r[2 - off]);
    if (!legal) return 32'd0;
    if (n == 4) return rd;
    v = rd >> (8 * off);
    return (n == 1) ? {{24{e & v[7]}}, v[7:0]} : {{16{e & v[15]}}, v[15:0]};
  endfunction

  // gd/rd: wait cycles before gnt/rvalid; fq: flush index in REQ (<gd), fr: flush index in RESP
  task automatic xact(input logic [31:0] a, input logic [3:0] w, input logic [3:0] r, input logic e,
                      input logic [31:0] d, input int gd, input int rd, input int fq, input int fr,
                      input logic [31:0] rdat);
    int k, ph, p0, stalls, exp_st;
    bit fin, killed, ld;
    ld = (w == 4'd0);
    killed = 0;
    fin = 0;
    @(negedge clk);
    dce = 1; daddr = a; we = w; dre = r; extendtype = e; din = d; flush = 0;
    #1 stalls = stallreq;
    ph = 1;
    k = 0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      p0 = ph;
      if (ph == 1) begin
        if (k == 0) begin
          chk("bus_req", bus_req, 1);
          chk("bus_addr", bus_addr, {a[31:2], 2'b00});
          chk("bus_wr", bus_wr, {31'd0, |w});
          chk("bus_wstrb", bus_wstrb, w);
          chk("bus_wdata", bus_wdata, d);
        end
        if (k == fq) begin
          flush = 1; dce = 0; ph = 4;
        end else begin
          bus_gnt = (k == gd);
          if (k == gd) begin ph = 2; k = -1; end
        end
        k++;
      end else if (ph == 2) begin
        bus_gnt = 0;
        bus_rvalid = (k == rd);
        bus_rdata = (k == rd) ? rdat : $urandom;
        flush = (k == fr);
        if (k == fr) killed = 1;
        if (k == rd) ph = 3;
        k++;
      end else if (ph == 3) begin
        bus_rvalid = 0;
        flush = 0;
        if (!killed) exp_ld = ld ? ref_ld(r, e, rdat) : 32'd0;
        chk("load_valid", load_valid, {31'd0, ld & !killed});
        chk("load_data", load_data, exp_ld);
        chk("bus_err", bus_err, 0);
        if (killed) dce = 0;
        ph = 5;
      end else if (ph == 4) begin
        flush = 0;
        chk("req_dropped", bus_req, 0);
        chk("drop_lv", load_valid, 0);
        fin = 1;
      end else begin
        dce = 0;
        chk("no_reaccept", bus_req, 0);
        chk("lv_pulse", load_valid, 0);
        fin = 1;
      end
      #1;
      if (p0 == 1 || p0 == 2) stalls += stallreq;
      else chk("stall_low", stallreq, 0);
    end
    exp_st = (fq >= 0 && fq < gd) ? fq + 2 : gd + rd + 3;
    if (!fin) chk("hang", 0, 1);
    else chk("stall_cycles", stalls, exp_st);
    dce = 0; bus_gnt = 0; bus_rvalid = 0; flush = 0;
  endtask

  task automatic misaligned(input logic [31:0] a);
    @(negedge clk);
    dce = 1; daddr = a; we = 0; dre = 0; flush = 0;
    #1 chk("mis_stall", stallreq, 0);
    @(negedge clk);
    chk("mis_req", bus_req, 0);
    chk("mis_lv", load_valid, 0);
    #1 chk("mis_stall2", stallreq, 0);
    dce = 0;
  endtask

  initial begin
    logic [3:0] tbl [7];
    logic [3:0] w, r;
    int gd, rd, fq, fr;
    tbl = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b0011, 4'b1111};
    repeat (2) @(negedge clk);
    chk("rst_stall", stallreq, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_wr", bus_wr, 0);
    chk("rst_lv", load_valid, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wstrb", bus_wstrb, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_ldata", load_data, 0);
    rst = 0;
    xact(32'h100, 4'b0000, 4'b1111, 0, 32'h0, 0, 0, -1, -1, 32'hDEADBEEF);
    xact(32'h101, 4'b0000, 4'b0100, 1, 32'h0, 0, 0, -1, -1, 32'h0000_8000);
    xact(32'h102, 4'b0000, 4'b0011, 0, 32'h0, 3, 0, -1, -1, 32'h8001_0000);
    xact(32'h103, 4'b1000, 4'b0000, 0, 32'h5A5A5A5A, 0, 0, -1, -1, 32'h0);
    misaligned(32'h0000_0206);
    xact(32'h104, 4'b0000, 4'b1111, 0, 32'h0, 0, 2, -1, 1, 32'h12345678);
    xact(32'h108, 4'b0000, 4'b1100, 1, 32'h0, 1, 1, -1, 1, 32'hFFFF_FFFF);
    xact(32'h10C, 4'b0000, 4'b1111, 0, 32'h0, 3, 0, 1, -1, 32'hCAFEF00D);
    xact(32'h110, 4'b0000, 4'b0110, 1, 32'h0, 0, 1, -1, -1, 32'hFFFF_FFFF);
    // reset mid-transaction, then a stray rvalid in IDLE
    @(negedge clk); dce = 1; daddr = 32'h200; we = 0; dre = 4'b1111;
    @(negedge clk); bus_gnt = 1;
    @(negedge clk); bus_gnt = 0; rst = 1; dce = 0;
    @(negedge clk); rst = 0; bus_rvalid = 1; bus_rdata = 32'h13579BDF;
    chk("mrst_req", bus_req, 0);
    chk("mrst_addr", bus_addr, 0);
    chk("mrst_ldata", load_data, 0);
    #1 chk("mrst_stall", stallreq, 0);
    exp_ld = 0;
    @(negedge clk); bus_rvalid = 0;
    chk("late_rv_lv", load_valid, 0);
    chk("late_rv_req", bus_req, 0);
    chk("late_rv_ldata", load_data, 0);
`ifdef DMEM_TIMEOUT_EN
    begin
      int n;
      bit hit;
      n = 0;
      hit = 0;
      @(negedge clk); dce = 1; daddr = 32'h300; we = 0; dre = 4'b1111;
      @(negedge clk); dce = 0;
      for (int c = 0; c < 50 && !hit; c++) begin
        if (bus_err) hit = 1;
        else begin
          n += bus_req;
          @(negedge clk);
        end
      end
      chk("to_seen", {31'd0, hit}, 1);
      chk("to_cycles", n, 8);
      chk("to_lv", load_valid, 0);
      chk("to_ldata", load_data, 0);
      exp_ld = 0;
      @(negedge clk);
      chk("to_pulse", bus_err, 0);
      chk("to_idle", bus_req, 0);
    end
`else
    xact(32'h300, 4'b0000, 4'b1111, 0, 32'h0, 20, 0, -1, -1, 32'h0BADF00D);
    chk("no_err", bus_err, 0);
`endif
    for (int i = 0; i < 60; i++) begin
      gd = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      fq = (gd > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, gd - 1) : -1;
      fr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rd) : -1;
      if ($urandom_range(0, 9) < 6) begin
        w = 0;
        r = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : tbl[$urandom_range(0, 6)];
      end else begin
        w = 4'($urandom_range(1, 15));
        r = 0;
      end
      xact($urandom, w, r, 1'($urandom_range(0, 1)), $urandom, gd, rd, fq, fr, $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
